// File: rtl/retire_release_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : retire_release_scheduler
// Description : Collects up to RETIRE_PORTS physical-register release requests
//               per cycle into a circular queue and hands them to the
//               renamer's single retire port one per cycle, in program order.
//               Accept and release both stall while the renamer's post-reset
//               table initialization (init_clear) is running.
// Revision    : 1.0 - initial release
// ============================================================================
module retire_release_scheduler #(
  parameter int RETIRE_PORTS = 2,
  parameter int DEPTH        = 8,
  parameter int ID_W         = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                init_clear,
  input  logic [RETIRE_PORTS-1:0]             retire_valid,
  input  logic [RETIRE_PORTS-1:0][ID_W-1:0]   retire_id,
  input  logic [RETIRE_PORTS-1:0]             retire_suppress,
  output logic                                retire_ready,
  output logic                                release_valid,
  output logic [ID_W-1:0]                     release_id,
  output logic                                release_suppress,
  output logic [$clog2(DEPTH):0]              occupancy,
  output logic                                overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry storage: several write ports, one asynchronous read at rd_ptr.
  logic [ID_W-1:0]  mem_id_q  [DEPTH];
  logic             mem_sup_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occupancy_q, occupancy_d;
  logic             overflow_q, overflow_d;

  logic [CNT_W-1:0]              w_free_cnt;
  logic [CNT_W-1:0]              w_accept_cnt;
  logic [RETIRE_PORTS-1:0]       w_wr_en;
  logic [PTR_W-1:0]              w_wr_addr [RETIRE_PORTS];

  // Outputs come from registered state plus init_clear only; rst masks the
  // release so nothing leaves the queue in the cycle it is being discarded.
  always_comb begin
    w_free_cnt       = CNT_W'(DEPTH) - occupancy_q;
    retire_ready     = ~init_clear & (w_free_cnt >= CNT_W'(RETIRE_PORTS));
    release_valid    = ~rst & ~init_clear & (occupancy_q != '0);
    release_id       = mem_id_q[rd_ptr_q];
    release_suppress = mem_sup_q[rd_ptr_q];
    occupancy        = occupancy_q;
    overflow_err     = overflow_q;
  end

  // Compact valid ports into consecutive slots and compute next pointer state.
  always_comb begin
    w_accept_cnt = '0;
    w_wr_en      = '0;
    for (int p = 0; p < RETIRE_PORTS; p++) begin
      w_wr_addr[p] = wr_ptr_q;
    end
    if (retire_ready) begin
      for (int p = 0; p < RETIRE_PORTS; p++) begin
        if (retire_valid[p]) begin
          w_wr_en[p]   = 1'b1;
          w_wr_addr[p] = wr_ptr_q + PTR_W'(w_accept_cnt);
          w_accept_cnt = w_accept_cnt + CNT_W'(1);
        end
      end
    end
    wr_ptr_d    = wr_ptr_q + PTR_W'(w_accept_cnt);
    rd_ptr_d    = rd_ptr_q + PTR_W'(release_valid);
    occupancy_d = occupancy_q + w_accept_cnt - CNT_W'(release_valid);
    overflow_d  = overflow_q | ((|retire_valid) & ~retire_ready);
  end

  // Pointer, occupancy and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occupancy_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occupancy_q <= occupancy_d;
      overflow_q  <= overflow_d;
    end
  end

  // Entry writes; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int p = 0; p < RETIRE_PORTS; p++) begin
      if (w_wr_en[p]) begin
        mem_id_q[w_wr_addr[p]]  <= retire_id[p];
        mem_sup_q[w_wr_addr[p]] <= retire_suppress[p];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_retire_release_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_retire_release_scheduler
// Description : Scoreboard bench for retire_release_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_retire_release_scheduler;

  localparam int RP    = 2;
  localparam int DEPTH = 8;
  localparam int ID_W  = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     init_clear;
  logic [RP-1:0]            retire_valid;
  logic [RP-1:0][ID_W-1:0]  retire_id;
  logic [RP-1:0]            retire_suppress;
  logic                     retire_ready;
  logic                     release_valid;
  logic [ID_W-1:0]          release_id;
  logic                     release_suppress;
  logic [3:0]               occupancy;
  logic                     overflow_err;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            sup;
  } ent_t;

  ent_t q[$];
  logic exp_ovf = 1'b0;
  int   passed  = 0;
  int   total   = 0;

  always #5 clk = ~clk;

  retire_release_scheduler #(.RETIRE_PORTS(RP), .DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .init_clear       (init_clear),
    .retire_valid     (retire_valid),
    .retire_id        (retire_id),
    .retire_suppress  (retire_suppress),
    .retire_ready     (retire_ready),
    .release_valid    (release_valid),
    .release_id       (release_id),
    .release_suppress (release_suppress),
    .occupancy        (occupancy),
    .overflow_err     (overflow_err)
  );

  function automatic logic exp_ready();
    return !init_clear && ((DEPTH - q.size()) >= RP);
  endfunction

  function automatic logic exp_rv();
    return !rst && !init_clear && (q.size() != 0);
  endfunction

  task automatic drive(input logic [1:0] v, input logic [7:0] id0, input logic [7:0] id1,
                       input logic [1:0] s);
    retire_valid       = v;
    retire_id[0]       = id0;
    retire_id[1]       = id1;
    retire_suppress    = s;
  endtask

  // Advance the reference model by one edge, then the clock.
  task automatic tick();
    logic rdy;
    logic rv;
    rdy = exp_ready();
    rv  = exp_rv();
    if (rv) void'(q.pop_front());
    if (rst) begin
      q.delete();
      exp_ovf = 1'b0;
    end else if (rdy) begin
      for (int p = 0; p < RP; p++)
        if (retire_valid[p]) q.push_back('{id: retire_id[p], sup: retire_suppress[p]});
    end else if (|retire_valid) begin
      exp_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; init_clear = 1'b0; drive(2'b00, 8'd0, 8'd0, 2'b00);
    tick(); tick();
    rst = 1'b0; #1;
    total++; if (occupancy !== 4'd0) $display("FAIL reset_occ got=%0d want=0", occupancy); else passed++;
    total++; if (release_valid !== 1'b0) $display("FAIL reset_rv got=%0b want=0", release_valid); else passed++;
    total++; if (retire_ready !== 1'b1) $display("FAIL reset_ready got=%0b want=1", retire_ready); else passed++;
    total++; if (overflow_err !== 1'b0) $display("FAIL reset_ovf got=%0b want=0", overflow_err); else passed++;
  endtask

  task automatic test_single();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive(2'b01, 8'd5, 8'd0, 2'b00); else drive(2'b00, 8'd0, 8'd0, 2'b00);
      #1;
      total++; if (occupancy !== 4'(q.size())) $display("FAIL single_occ c=%0d got=%0d want=%0d", c, occupancy, q.size()); else passed++;
      total++; if (release_valid !== exp_rv()) $display("FAIL single_rv c=%0d got=%0b want=%0b", c, release_valid, exp_rv()); else passed++;
      if (exp_rv()) begin
        total++; if ({release_id, release_suppress} !== q[0]) $display("FAIL single_id c=%0d got=%0d/%0b want=%0d/%0b", c, release_id, release_suppress, q[0].id, q[0].sup); else passed++;
      end
      tick();
    end
  endtask

  task automatic test_burst_gap();
    for (int c = 0; c < 6; c++) begin
      case (c)
        0:       drive(2'b11, 8'd3, 8'd7, 2'b00);
        1:       drive(2'b10, 8'd0, 8'd9, 2'b00);
        default: drive(2'b00, 8'd0, 8'd0, 2'b00);
      endcase
      #1;
      total++; if (occupancy !== 4'(q.size())) $display("FAIL burst_occ c=%0d got=%0d want=%0d", c, occupancy, q.size()); else passed++;
      total++; if (release_valid !== exp_rv()) $display("FAIL burst_rv c=%0d got=%0b want=%0b", c, release_valid, exp_rv()); else passed++;
      if (exp_rv()) begin
        total++; if ({release_id, release_suppress} !== q[0]) $display("FAIL burst_id c=%0d got=%0d want=%0d", c, release_id, q[0].id); else passed++;
      end
      tick();
    end
  endtask

  task automatic test_fill_full();
    int   nid;
    logic saw_low;
    nid = 0; saw_low = 1'b0;
    for (int c = 0; c < 80 && (nid < 16 || q.size() != 0); c++) begin
      if (exp_ready() && nid < 16)
        drive(2'b11, 8'(nid), 8'(nid + 1), {nid[1], ~nid[1]});
      else
        drive(2'b00, 8'd0, 8'd0, 2'b00);
      #1;
      if (!exp_ready()) saw_low = 1'b1;
      total++; if (retire_ready !== exp_ready()) $display("FAIL fill_ready c=%0d got=%0b want=%0b occ=%0d", c, retire_ready, exp_ready(), q.size()); else passed++;
      total++; if (occupancy !== 4'(q.size())) $display("FAIL fill_occ c=%0d got=%0d want=%0d", c, occupancy, q.size()); else passed++;
      total++; if (release_valid !== exp_rv()) $display("FAIL fill_rv c=%0d got=%0b want=%0b", c, release_valid, exp_rv()); else passed++;
      if (exp_rv()) begin
        total++; if ({release_id, release_suppress} !== q[0]) $display("FAIL fill_id c=%0d got=%0d/%0b want=%0d/%0b", c, release_id, release_suppress, q[0].id, q[0].sup); else passed++;
      end
      if (retire_valid != 2'b00) nid += 2;
      tick();
    end
    total++; if (!saw_low) $display("FAIL fill_ready_drop got=never want=dropped"); else passed++;
    total++; if (nid != 16 || q.size() != 0) $display("FAIL fill_timeout got=%0d sent %0d left want=16 sent 0 left", nid, q.size()); else passed++;
    total++; if (overflow_err !== 1'b0) $display("FAIL fill_ovf got=%0b want=0", overflow_err); else passed++;
  endtask

  task automatic test_init_clear();
    for (int c = 0; c < 72; c++) begin
      init_clear = (c >= 2 && c < 66);
      case (c)
        0:       drive(2'b11, 8'h20, 8'h21, 2'b10);
        1:       drive(2'b11, 8'h22, 8'h23, 2'b00);
        default: drive(2'b00, 8'd0, 8'd0, 2'b00);
      endcase
      #1;
      total++; if (occupancy !== 4'(q.size())) $display("FAIL init_occ c=%0d got=%0d want=%0d", c, occupancy, q.size()); else passed++;
      total++; if (release_valid !== exp_rv()) $display("FAIL init_rv c=%0d got=%0b want=%0b", c, release_valid, exp_rv()); else passed++;
      total++; if (retire_ready !== exp_ready()) $display("FAIL init_ready c=%0d got=%0b want=%0b", c, retire_ready, exp_ready()); else passed++;
      if (exp_rv()) begin
        total++; if ({release_id, release_suppress} !== q[0]) $display("FAIL init_id c=%0d got=%0h/%0b want=%0h/%0b", c, release_id, release_suppress, q[0].id, q[0].sup); else passed++;
      end
      tick();
    end
    init_clear = 1'b0;
  endtask

  task automatic test_overflow();
    for (int c = 0; c < 5; c++) begin
      init_clear = (c == 0);
      if (c == 0) drive(2'b01, 8'hEE, 8'd0, 2'b00); else drive(2'b00, 8'd0, 8'd0, 2'b00);
      #1;
      total++; if (overflow_err !== exp_ovf) $display("FAIL ovf_flag c=%0d got=%0b want=%0b", c, overflow_err, exp_ovf); else passed++;
      total++; if (occupancy !== 4'(q.size())) $display("FAIL ovf_occ c=%0d got=%0d want=%0d", c, occupancy, q.size()); else passed++;
      total++; if (release_valid !== exp_rv()) $display("FAIL ovf_rv c=%0d got=%0b want=%0b", c, release_valid, exp_rv()); else passed++;
      tick();
    end
    init_clear = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 10; c++) begin
      rst = (c == 4);
      if (c < 4)       drive(2'b11, 8'(8'h40 + 2 * c), 8'(8'h41 + 2 * c), 2'b01);
      else if (c == 5) drive(2'b01, 8'h77, 8'd0, 2'b10);
      else             drive(2'b00, 8'd0, 8'd0, 2'b00);
      #1;
      total++; if (occupancy !== 4'(q.size())) $display("FAIL rstmid_occ c=%0d got=%0d want=%0d", c, occupancy, q.size()); else passed++;
      total++; if (release_valid !== exp_rv()) $display("FAIL rstmid_rv c=%0d got=%0b want=%0b", c, release_valid, exp_rv()); else passed++;
      total++; if (overflow_err !== exp_ovf) $display("FAIL rstmid_ovf c=%0d got=%0b want=%0b", c, overflow_err, exp_ovf); else passed++;
      if (exp_rv()) begin
        total++; if ({release_id, release_suppress} !== q[0]) $display("FAIL rstmid_id c=%0d got=%0h want=%0h", c, release_id, q[0].id); else passed++;
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    init_clear = 1'b0;
    drive(2'b00, 8'd0, 8'd0, 2'b00);
    test_reset();
    test_single();
    test_burst_gap();
    test_fill_full();
    test_init_clear();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
